// File: rtl/jtag_debug_top.sv
// JTAG debug slave: oversampled TAP controller with IDCODE, BYPASS and
// address/data scan access to a small scratch register file, all on clk.
module jtag_debug_top #(
   parameter logic [31:0] IDCODE = 32'h1495_11C3,
   parameter int          NREGS  = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic tap_tck,
   input  logic tap_tms,
   input  logic tap_tdi,
   output logic tap_tdo,
   input  logic test_mode
);

   localparam int         AW        = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [8:0] NREGS_LIM = 9'(NREGS);

   localparam logic [3:0] IR_IDCODE = 4'h1;
   localparam logic [3:0] IR_ADDR   = 4'h2;
   localparam logic [3:0] IR_DATA   = 4'h3;

   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
   } tap_state_t;

   logic [1:0]  tck_s;
   logic [1:0]  tms_s;
   logic [1:0]  tdi_s;
   logic        tck_d;
   logic        tck_rise;
   logic        tck_fall;

   tap_state_t  state;
   tap_state_t  state_next;
   logic [3:0]  ir;
   logic [3:0]  ir_sr;
   logic [31:0] dr_sr;
   logic [7:0]  addr;
   logic [31:0] regs [NREGS];
   logic        addr_in_range;
   logic [31:0] capture_val;

   function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
      case (s)
         TLR:      return tms ? TLR      : RTI;
         RTI:      return tms ? SEL_DR   : RTI;
         SEL_DR:   return tms ? SEL_IR   : CAP_DR;
         CAP_DR:   return tms ? EX1_DR   : SH_DR;
         SH_DR:    return tms ? EX1_DR   : SH_DR;
         EX1_DR:   return tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: return tms ? EX2_DR   : PAUSE_DR;
         EX2_DR:   return tms ? UPD_DR   : SH_DR;
         UPD_DR:   return tms ? SEL_DR   : RTI;
         SEL_IR:   return tms ? TLR      : CAP_IR;
         CAP_IR:   return tms ? EX1_IR   : SH_IR;
         SH_IR:    return tms ? EX1_IR   : SH_IR;
         EX1_IR:   return tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: return tms ? EX2_IR   : PAUSE_IR;
         EX2_IR:   return tms ? UPD_IR   : SH_IR;
         UPD_IR:   return tms ? SEL_DR   : RTI;
         default:  return TLR;
      endcase
   endfunction

   // Pin oversampling; the extra tck copy turns the synced level into one-clk edge strobes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tck_s <= '0;
         tms_s <= '0;
         tdi_s <= '0;
         tck_d <= 1'b0;
      end else begin
         tck_s <= {tck_s[0], tap_tck};
         tms_s <= {tms_s[0], tap_tms};
         tdi_s <= {tdi_s[0], tap_tdi};
         tck_d <= tck_s[1];
      end
   end

   assign tck_rise      = tck_s[1] & ~tck_d;
   assign tck_fall      = ~tck_s[1] & tck_d;
   assign state_next    = next_state(state, tms_s[1]);
   assign addr_in_range = {1'b0, addr} < NREGS_LIM;

   always_comb begin
      capture_val = '0;
      case (ir)
         IR_IDCODE: capture_val = IDCODE;
         IR_ADDR:   capture_val = {24'h0, addr};
         IR_DATA:   capture_val = addr_in_range ? regs[addr[AW-1:0]] : '0;
         default:   capture_val = '0;
      endcase
   end

   // Every TAP action is gated by tck_rise, so capture and update fire exactly once per scan.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= TLR;
         ir    <= IR_IDCODE;
         ir_sr <= '0;
         dr_sr <= '0;
         addr  <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         tap_tdo <= 1'b0;
      end else begin
         if (tck_rise) begin
            state <= state_next;
            case (state)
               CAP_IR: ir_sr <= 4'b0101;
               SH_IR:  ir_sr <= {tdi_s[1], ir_sr[3:1]};
               CAP_DR: dr_sr <= capture_val;
               SH_DR: begin
                  case (ir)
                     IR_IDCODE, IR_DATA: dr_sr      <= {tdi_s[1], dr_sr[31:1]};
                     IR_ADDR:            dr_sr[7:0] <= {tdi_s[1], dr_sr[7:1]};
                     default:            dr_sr[0]   <= tdi_s[1];
                  endcase
               end
               default: ;
            endcase
            if (state_next == TLR) begin
               ir <= IR_IDCODE;
            end else if (state_next == UPD_IR) begin
               ir <= ir_sr;
            end
            if (state_next == UPD_DR) begin
               case (ir)
                  IR_ADDR: addr <= dr_sr[7:0];
                  IR_DATA: begin
                     if (addr_in_range) regs[addr[AW-1:0]] <= dr_sr;
                     addr <= addr + 8'd1;
                  end
                  default: ;
               endcase
            end
         end
         if (test_mode) begin
            tap_tdo <= tdi_s[1];
         end else if (tck_fall) begin
            if (state == SH_DR)      tap_tdo <= dr_sr[0];
            else if (state == SH_IR) tap_tdo <= ir_sr[0];
            else                     tap_tdo <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_jtag_debug_top.sv
// Directed-plus-random bench for jtag_debug_top: bit-bangs TCK/TMS/TDI and
// compares every scan result against a register-level model of the debug block.
module tb_jtag_debug_top;

   localparam logic [31:0] IDCODE = 32'h1495_11C3;
   localparam int          NREGS  = 16;
   localparam int          HALF   = 4;

   logic clk       = 1'b0;
   logic rst       = 1'b0;
   logic tap_tck   = 1'b0;
   logic tap_tms   = 1'b0;
   logic tap_tdi   = 1'b0;
   logic test_mode = 1'b0;
   logic tap_tdo;

   int test_count = 0;
   int fail_count = 0;

   logic [3:0]  m_ir;
   int          m_addr;
   logic [31:0] m_regs [NREGS];
   logic        exit_tdo;
   logic        t;

   jtag_debug_top dut (
      .clk       (clk),
      .rst       (rst),
      .tap_tck   (tap_tck),
      .tap_tms   (tap_tms),
      .tap_tdi   (tap_tdi),
      .tap_tdo   (tap_tdo),
      .test_mode (test_mode)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_count++;
      assert (obs === exp) else begin
         fail_count++;
         $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One full TCK period; the returned TDO is what the host sees before the next rise.
   task automatic apply_stimulus(input logic tms_v, input logic tdi_v, output logic tdo_v);
      tap_tms = tms_v;
      tap_tdi = tdi_v;
      repeat (HALF) @(posedge clk);
      #1 tap_tck = 1'b1;
      repeat (HALF) @(posedge clk);
      #1 tap_tck = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 tdo_v = tap_tdo;
   endtask

   task automatic scan(input logic ir_path, input int w, input logic [31:0] din,
                       output logic [31:0] dout);
      logic b;
      dout = '0;
      apply_stimulus(1'b1, 1'b0, b);
      if (ir_path) apply_stimulus(1'b1, 1'b0, b);
      apply_stimulus(1'b0, 1'b0, b);
      apply_stimulus(1'b0, 1'b0, b);
      for (int i = 0; i < w; i++) begin
         dout[i] = b;
         apply_stimulus(i == w - 1, din[i], b);
      end
      exit_tdo = b;
      apply_stimulus(1'b1, 1'b0, b);
      apply_stimulus(1'b0, 1'b0, b);
   endtask

   task automatic ir_op(input logic [3:0] code);
      logic [31:0] d;
      scan(1'b1, 4, {28'h0, code}, d);
      check_output("ir_capture", d, 32'h5);
      m_ir = code;
   endtask

   // Expected capture comes from the model's view of the selected register.
   task automatic dr_op(input string tag, input int w, input logic [31:0] din);
      logic [31:0] d;
      logic [31:0] exp;
      logic [31:0] mask;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      case (m_ir)
         4'h1:    exp = IDCODE;
         4'h2:    exp = 32'(m_addr);
         4'h3:    exp = (m_addr < NREGS) ? m_regs[m_addr] : 32'h0;
         default: exp = din << 1;
      endcase
      scan(1'b0, w, din, d);
      check_output(tag, d, exp & mask);
      check_output({tag, "_exit_tdo"}, {31'h0, exit_tdo}, 32'h0);
      if (m_ir == 4'h2) begin
         m_addr = int'(din[7:0]);
      end else if (m_ir == 4'h3) begin
         if (m_addr < NREGS) m_regs[m_addr] = din;
         m_addr = (m_addr + 1) % 256;
      end
   endtask

   task automatic model_reset();
      m_ir   = 4'h1;
      m_addr = 0;
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
   endtask

   initial begin
      logic [31:0] v;
      logic [7:0]  a;
      logic [3:0]  tdi_seq;
      logic        prev;

      model_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_output("reset_tdo", {31'h0, tap_tdo}, 32'h0);
      rst = 1'b1;

      repeat (5) apply_stimulus(1'b1, 1'b0, t);
      apply_stimulus(1'b0, 1'b0, t);
      dr_op("idcode_default", 32, $urandom());

      ir_op(4'hF);
      dr_op("bypass_a5", 8, 32'hA5);
      repeat (2) dr_op("bypass_rand", 16, $urandom());
      ir_op(4'h7);
      dr_op("bypass_other_code", 8, $urandom());
      ir_op(4'h1);
      dr_op("idcode_explicit", 32, $urandom());

      ir_op(4'h2); dr_op("addr_wr", 8, 32'h03);
      ir_op(4'h3); dr_op("data_wr", 32, 32'hDEAD_BEEF);
      ir_op(4'h2); dr_op("addr_wr2", 8, 32'h03);
      ir_op(4'h3); dr_op("data_rd", 32, 32'hDEAD_BEEF);
      ir_op(4'h2); dr_op("addr_inc", 8, 32'h04);

      ir_op(4'h2); dr_op("addr_oob", 8, 32'h20);
      ir_op(4'h3); dr_op("data_wr_oob", 32, 32'h1234_5678);
      ir_op(4'h2); dr_op("addr_oob_inc", 8, 32'h20);
      ir_op(4'h3); dr_op("data_rd_oob", 32, $urandom());
      ir_op(4'h2); dr_op("addr_ff", 8, 32'hFF);
      ir_op(4'h3); dr_op("data_at_ff", 32, $urandom());
      ir_op(4'h2); dr_op("addr_wrap", 8, 32'h00);

      // Random write/readback, including addresses just past the register file.
      repeat (4) begin
         a = 8'($urandom_range(0, NREGS + 3));
         v = $urandom();
         ir_op(4'h2); dr_op("rnd_addr", 8, {24'h0, a});
         ir_op(4'h3); dr_op("rnd_wr", 32, v);
         dr_op("rnd_next", 32, $urandom());
         ir_op(4'h2); dr_op("rnd_addr_rd", 8, {24'h0, a});
         ir_op(4'h3); dr_op("rnd_rd", 32, $urandom());
      end

      test_mode = 1'b1;
      tap_tdi = 1'b0;
      repeat (4) @(posedge clk);
      #1 check_output("tm_idle", {31'h0, tap_tdo}, 32'h0);
      tdi_seq = 4'b0110;
      prev = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tap_tdi = tdi_seq[i];
         repeat (2) @(posedge clk);
         #1 check_output("tm_not_yet", {31'h0, tap_tdo}, {31'h0, prev});
         @(posedge clk);
         #1 check_output("tm_follow", {31'h0, tap_tdo}, {31'h0, tdi_seq[i]});
         @(posedge clk);
         #1 prev = tdi_seq[i];
      end
      test_mode = 1'b0;

      ir_op(4'h2); dr_op("pre_rst_addr", 8, 32'h03);
      ir_op(4'h3); dr_op("pre_rst_wr", 32, 32'hFFFF_FFFF);
      ir_op(4'h2); dr_op("pre_rst_addr2", 8, 32'h03);
      ir_op(4'h3);
      apply_stimulus(1'b1, 1'b0, t);
      apply_stimulus(1'b0, 1'b0, t);
      apply_stimulus(1'b0, 1'b0, t);
      repeat (3) apply_stimulus(1'b0, 1'b1, t);
      check_output("mid_shift_tdo", {31'h0, t}, 32'h1);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_output("rst_mid_shift_tdo", {31'h0, tap_tdo}, 32'h0);
      rst = 1'b1;
      model_reset();
      apply_stimulus(1'b0, 1'b0, t);
      dr_op("idcode_after_rst", 32, $urandom());
      ir_op(4'h2); dr_op("addr_after_rst", 8, 32'h03);
      ir_op(4'h3); dr_op("reg_cleared", 32, $urandom());

      v = $urandom();
      ir_op(4'h2); dr_op("tlr_addr", 8, 32'h05);
      ir_op(4'h3); dr_op("tlr_wr", 32, v);
      ir_op(4'h2); dr_op("tlr_addr2", 8, 32'h05);
      ir_op(4'hF);
      apply_stimulus(1'b1, 1'b0, t);
      apply_stimulus(1'b0, 1'b0, t);
      apply_stimulus(1'b0, 1'b0, t);
      repeat (3) apply_stimulus(1'b0, 1'b1, t);
      repeat (5) apply_stimulus(1'b1, 1'b0, t);
      m_ir = 4'h1;
      apply_stimulus(1'b0, 1'b0, t);
      dr_op("idcode_after_tlr", 32, $urandom());
      ir_op(4'h2); dr_op("addr_kept", 8, 32'h05);
      ir_op(4'h3); dr_op("data_kept", 32, v);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
